comparison_engine: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle comparison unit in the integer execute path. It accepts two operands and an operation code over a valid/ready handshake, compares them MSB-first in `chunkWidth` slices with early termination, and returns the result over a second valid/ready handshake. Beyond the ten relational operations it adds signed and unsigned MIN/MAX modes that return a full operand. Operand width and slice width are independent, so wide operands can be compared without a full-width comparator.

---
 rtl/comparison_engine.sv | 167 ++++++++++++++++
 tb/tb_comparison_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparison_engine.sv
// Multi-cycle operand comparator: walks A and B MSB-first one chunkWidth slice per
// cycle, exits on the first differing slice, and returns a flag or a MIN/MAX operand.
module comparison_engine #(
    parameter int dataWidth   = 32,
    parameter int chunkWidth  = 8,
    parameter int selectWidth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [dataWidth-1:0]   inputA,
    input  logic [dataWidth-1:0]   inputB,
    input  logic [selectWidth-1:0] comparisonSelect,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [dataWidth-1:0]   dataOut,
    output logic                   busy
);

    localparam int NUM_CHUNKS = dataWidth / chunkWidth;
    localparam int IDX_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int NUM_SLOTS  = 2 ** IDX_WIDTH;

    if (dataWidth < 2) begin : g_bad_data_width
        $error("comparison_engine: dataWidth must be at least 2");
    end
    if (chunkWidth < 1 || (dataWidth % chunkWidth) != 0) begin : g_bad_chunk_width
        $error("comparison_engine: chunkWidth must divide dataWidth");
    end
    if (selectWidth < 4) begin : g_bad_select_width
        $error("comparison_engine: selectWidth must be at least 4");
    end

    localparam logic [selectWidth-1:0] OP_EQ   = 'd0;
    localparam logic [selectWidth-1:0] OP_NE   = 'd1;
    localparam logic [selectWidth-1:0] OP_LT   = 'd2;
    localparam logic [selectWidth-1:0] OP_LTU  = 'd3;
    localparam logic [selectWidth-1:0] OP_LE   = 'd4;
    localparam logic [selectWidth-1:0] OP_LEU  = 'd5;
    localparam logic [selectWidth-1:0] OP_GT   = 'd6;
    localparam logic [selectWidth-1:0] OP_GTU  = 'd7;
    localparam logic [selectWidth-1:0] OP_GE   = 'd8;
    localparam logic [selectWidth-1:0] OP_GEU  = 'd9;
    localparam logic [selectWidth-1:0] OP_MIN  = 'd10;
    localparam logic [selectWidth-1:0] OP_MAX  = 'd11;
    localparam logic [selectWidth-1:0] OP_MINU = 'd12;
    localparam logic [selectWidth-1:0] OP_MAXU = 'd13;

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and the result holds until it is taken.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [dataWidth-1:0]   a_q;
    logic [dataWidth-1:0]   b_q;
    logic [selectWidth-1:0] op_q;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [dataWidth-1:0]   data_q;

    logic                   accept;
    logic                   is_signed;
    logic [dataWidth-1:0]   msb_flip;
    logic [dataWidth-1:0]   a_cmp;
    logic [dataWidth-1:0]   b_cmp;
    logic [chunkWidth-1:0]  a_slices [NUM_SLOTS];
    logic [chunkWidth-1:0]  b_slices [NUM_SLOTS];
    logic [chunkWidth-1:0]  slice_a;
    logic [chunkWidth-1:0]  slice_b;
    logic                   slice_lt;
    logic                   slice_gt;
    logic                   last_slice;
    logic                   rel_bit;
    logic [dataWidth-1:0]   result;

    assign inReady  = (state == IDLE) && !reset;
    assign accept   = inValid && inReady;
    assign outValid = (state == DONE);
    assign busy     = (state != IDLE);
    assign dataOut  = data_q;

    // Flipping the sign bit of both operands turns a signed order into an unsigned one.
    assign is_signed = op_q inside {OP_LT, OP_LE, OP_GT, OP_GE, OP_MIN, OP_MAX};
    assign msb_flip  = is_signed ? {1'b1, {(dataWidth-1){1'b0}}} : '0;
    assign a_cmp     = a_q ^ msb_flip;
    assign b_cmp     = b_q ^ msb_flip;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slices
        if (i < NUM_CHUNKS) begin : g_real
            assign a_slices[i] = a_cmp[i*chunkWidth +: chunkWidth];
            assign b_slices[i] = b_cmp[i*chunkWidth +: chunkWidth];
        end else begin : g_pad
            assign a_slices[i] = '0;
            assign b_slices[i] = '0;
        end
    end

    assign slice_a    = a_slices[idx_q];
    assign slice_b    = b_slices[idx_q];
    assign slice_lt   = slice_a < slice_b;
    assign slice_gt   = slice_a > slice_b;
    assign last_slice = (idx_q == '0);

    always_comb begin
        rel_bit = 1'b0;
        result  = '0;
        unique case (op_q)
            OP_EQ:          rel_bit = !slice_lt && !slice_gt;
            OP_NE:          rel_bit = slice_lt || slice_gt;
            OP_LT, OP_LTU:  rel_bit = slice_lt;
            OP_LE, OP_LEU:  rel_bit = !slice_gt;
            OP_GT, OP_GTU:  rel_bit = slice_gt;
            OP_GE, OP_GEU:  rel_bit = !slice_lt;
            default:        rel_bit = 1'b0;
        endcase
        // Ties in MIN/MAX fall through to A.
        if (op_q == OP_MIN || op_q == OP_MINU) begin
            result = slice_gt ? b_q : a_q;
        end else if (op_q == OP_MAX || op_q == OP_MAXU) begin
            result = slice_lt ? b_q : a_q;
        end else begin
            result[0] = rel_bit;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = COMPARE;
            COMPARE: if (slice_lt || slice_gt || last_slice) state_next = DONE;
            DONE:    if (outReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            data_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            idx_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q   <= inputA;
                b_q   <= inputB;
                op_q  <= comparisonSelect;
                idx_q <= IDX_WIDTH'(NUM_CHUNKS - 1);
            end
            if (state == COMPARE) begin
                if (state_next == DONE) begin
                    data_q <= result;
                end else begin
                    idx_q <= idx_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_comparison_engine.sv
// Directed and randomised bench for comparison_engine at chunkWidth 8, 1 and 32,
// checking result values and the number of slices walked against a reference model.
module tb_comparison_engine;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [3:0]  comparison_select;
    logic        in_valid  [NDUT];
    logic        out_ready [NDUT];
    logic        in_ready  [NDUT];
    logic        out_valid [NDUT];
    logic        busy      [NDUT];
    logic [31:0] data_out  [NDUT];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CW = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
        comparison_engine #(
            .dataWidth(32),
            .chunkWidth(CW),
            .selectWidth(4)
        ) dut (
            .clk(clk),
            .reset(reset),
            .inValid(in_valid[g]),
            .inReady(in_ready[g]),
            .inputA(input_a),
            .inputB(input_b),
            .comparisonSelect(comparison_select),
            .outValid(out_valid[g]),
            .outReady(out_ready[g]),
            .dataOut(data_out[g]),
            .busy(busy[g])
        );
    end

    function automatic int chunk_of(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 1 : 32);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_value(input logic [31:0] a, input logic [31:0] b,
                                                input logic [3:0] op);
        case (op)
            4'd0:  return {31'd0, a == b};
            4'd1:  return {31'd0, a != b};
            4'd2:  return {31'd0, $signed(a) <  $signed(b)};
            4'd3:  return {31'd0, a <  b};
            4'd4:  return {31'd0, $signed(a) <= $signed(b)};
            4'd5:  return {31'd0, a <= b};
            4'd6:  return {31'd0, $signed(a) >  $signed(b)};
            4'd7:  return {31'd0, a >  b};
            4'd8:  return {31'd0, $signed(a) >= $signed(b)};
            4'd9:  return {31'd0, a >= b};
            4'd10: return ($signed(a) <= $signed(b)) ? a : b;
            4'd11: return ($signed(a) >= $signed(b)) ? a : b;
            4'd12: return (a <= b) ? a : b;
            4'd13: return (a >= b) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    // Slices examined: position of the first differing slice counted from the top.
    function automatic int model_k(input logic [31:0] a, input logic [31:0] b, input int cw);
        int nc = 32 / cw;
        logic [63:0] mask = (64'd1 << cw) - 64'd1;
        for (int i = nc - 1; i >= 0; i--) begin
            if ((({32'd0, a} >> (i * cw)) & mask) != (({32'd0, b} >> (i * cw)) & mask))
                return nc - i;
        end
        return nc;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, output logic [31:0] res, output int lat);
        int guard = 0;
        input_a = a;
        input_b = b;
        comparison_select = op;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b1;
        while (!in_ready[d] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        input_a = ~a;
        input_b = ~b;
        comparison_select = 4'(op + 4'd3);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[d] && lat < 100);
        if (lat >= 100) check("result_timeout", 32'd1, 32'd0);
        res = data_out[d];
        @(posedge clk); #1;
    endtask

    logic [31:0] res;
    int          lat;
    int          valid_seen;

    initial begin
        reset = 1'b1;
        input_a = '0;
        input_b = '0;
        comparison_select = '0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end

        // Reset state on every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("rst_out_valid", 32'(out_valid[d]), 32'd0);
            check("rst_data_out", data_out[d], 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_in_ready", 32'(in_ready[d]), 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) check("rel_in_ready", 32'(in_ready[d]), 32'd1);
        @(posedge clk); #1;

        // Signed vs unsigned with an early exit on the top slice.
        run_op(0, 32'h8000_0000, 32'h0000_0001, 4'd2, res, lat);
        check("lt_val", res, 32'd1);
        check("lt_lat", 32'(lat), 32'd1);
        run_op(0, 32'h8000_0000, 32'h0000_0001, 4'd3, res, lat);
        check("ltu_val", res, 32'd0);
        run_op(0, 32'h8000_0000, 32'h0000_0001, 4'd6, res, lat);
        check("gt_val", res, 32'd0);

        // Equal operands walk all four slices.
        run_op(0, 32'h1234_5678, 32'h1234_5678, 4'd0, res, lat);
        check("eq_val", res, 32'd1);
        check("eq_lat", 32'(lat), 32'd4);
        run_op(0, 32'h1234_5678, 32'h1234_5678, 4'd8, res, lat);
        check("ge_val", res, 32'd1);
        check("ge_lat", 32'(lat), 32'd4);
        run_op(0, 32'h1234_5678, 32'h1234_5678, 4'd1, res, lat);
        check("ne_val", res, 32'd0);
        check("ne_lat", 32'(lat), 32'd4);

        // MIN/MAX return full operands.
        run_op(0, 32'h1234_5677, 32'h1234_5678, 4'd12, res, lat);
        check("minu_val", res, 32'h1234_5677);
        check("minu_lat", 32'(lat), 32'd4);
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 4'd11, res, lat);
        check("max_val", res, 32'h0000_0000);
        check("max_lat", 32'(lat), 32'd1);
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 4'd13, res, lat);
        check("maxu_val", res, 32'hFFFF_FFFF);
        check("maxu_lat", 32'(lat), 32'd1);
        run_op(0, 32'h0000_0042, 32'h0000_0042, 4'd10, res, lat);
        check("min_tie", res, 32'h0000_0042);

        // Backpressure: GTU 0x01000000 > 0 finishes in one slice, then is held.
        input_a = 32'h0100_0000;
        input_b = 32'h0000_0000;
        comparison_select = 4'd7;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[0] && lat < 100);
        check("bp_lat", 32'(lat), 32'd1);
        input_a = 32'h0000_0007;
        input_b = 32'h0000_0007;
        comparison_select = 4'd1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid[0]), 32'd1);
            check("bp_data_out", data_out[0], 32'd1);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", 32'(in_ready[0]), 32'd1);
        check("bp_release_valid", 32'(out_valid[0]), 32'd0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("bp_next_accept", 32'(busy[0]), 32'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[0] && lat < 100);
        check("bp_next_val", data_out[0], 32'd0);
        check("bp_next_lat", 32'(lat), 32'd4);
        @(posedge clk); #1;

        // Reset during the second compare cycle of a full-walk EQ.
        run_op(0, 32'h0000_0002, 32'h0000_0001, 4'd7, res, lat);
        check("pre_rst_val", res, 32'd1);
        input_a = 32'hCAFE_F00D;
        input_b = 32'hCAFE_F00D;
        comparison_select = 4'd0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_rst_data_out", data_out[0], 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_rel_ready", 32'(in_ready[0]), 32'd1);
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid[0]) valid_seen++;
        end
        check("mid_rst_no_result", 32'(valid_seen), 32'd0);

        // Invalid opcodes, each after a nonzero result.
        run_op(0, 32'h0000_0009, 32'h0000_0003, 4'd13, res, lat);
        check("pre_inv_val", res, 32'h0000_0009);
        run_op(0, 32'h0000_0009, 32'h0000_0003, 4'd14, res, lat);
        check("inv14_val", res, 32'd0);
        check("inv14_lat", 32'(lat), 32'd4);
        run_op(0, 32'h0000_0009, 32'h0000_0009, 4'd11, res, lat);
        check("pre_inv15_val", res, 32'h0000_0009);
        run_op(0, 32'h0000_0009, 32'h0000_0009, 4'd15, res, lat);
        check("inv15_val", res, 32'd0);

        // Randomised against the reference model on all three slice widths.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 24; n++) begin
                logic [31:0] a;
                logic [31:0] b;
                logic [3:0]  op;
                int          k;
                a  = $urandom;
                op = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       b = a;
                    1:       b = a ^ (32'd1 << $urandom_range(0, 31));
                    default: b = $urandom;
                endcase
                k = model_k(a, b, chunk_of(d));
                exp_q.push_back(model_value(a, b, op));
                run_op(d, a, b, op, res, lat);
                check("rand_val", res, exp_q.pop_front());
                check("rand_lat", 32'(lat), 32'(k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
